rcpu_mem_responder: RTL and testbench
=====================================

// Module: rcpu_mem_responder
// PURPOSE
//   Responder end of the RCPU memory bus. Decodes the 32-bit word address and serves:
//     - word RAM
//     - a console-output byte FIFO with a valid/ready drain port
//     - a status register
//     - a free-running 32-bit cycle counter
//   Read data is combinational, so the CPU samples it in the same cycle as memRE (zero wait states).
// PARAMETERS
//   M          16              data width (fixed 16, matches CPU)
//   N          32              address width
//   RAM_AW     16              RAM occupies word addresses 0 .. 2**RAM_AW-1
//   FIFO_DEPTH 8               console FIFO entries (power of 2, >=2)
//   MMIO_BASE  32'hFFFF_FF00   base of the register window (offsets 0..255)
//   ROM_WORDS  256             size of the protected low region (see CONFIGURATION)
// PORTS
//   clk        in   1   clock; all state updates on the rising edge
//   rst        in   1   asynchronous, active-low reset
//   memAddr    in   N   word address from CPU
//   memRead    out  M   read data to CPU (combinational)
//   memWrite   in   M   write data from CPU
//   memRE      in   1   read enable
//   memWE      in   1   write enable
//   out_data   out  8   FIFO head byte
//   out_valid  out  1   FIFO non-empty
//   out_ready  in   1   consumer accepts out_data this cycle
// BEHAVIOUR
//   Decode:
//     - RAM if memAddr < 2**RAM_AW.
//     - MMIO if memAddr[N-1:8] == MMIO_BASE[N-1:8].
//     - Anything else is unmapped: reads return 0, writes are ignored.
//   Reads: memRead = selected data when memRE=1, else 16'h0000.
//     - RAM reads are asynchronous and return pre-edge contents.
//     - With memRE & memWE both set on the same address, memRead shows the old data; the write lands at the edge.
//   RAM writes: array[addr] <= memWrite at the edge when memWE=1. Reset does not clear RAM.
//   MMIO map (offset: read / write):
//     0 CONOUT : read 0 / push memWrite[7:0] into FIFO
//     1 STATUS : read {12'b0, prot_err, ovf, full, empty} / write-1-clears bits 3 and 2
//     2 CYC_LO : read cnt[15:0]; the same edge latches cnt[31:16] into shadow / any write clears cnt
//     3 CYC_HI : read shadow / any write clears cnt
//     other    : read 0 / ignored
//   Read side effects fire on every edge with memRE=1 at that address (repeat reads re-latch).
//   FIFO:
//     - Push when memWE & CONOUT & !full.
//     - Push while full: byte dropped and ovf<=1. This holds even if a pop happens in the same cycle; full is judged on pre-edge state.
//     - Pop when out_valid & out_ready.
//     - Push and pop in the same cycle when not full and not empty: count unchanged.
//     - out_valid and out_data are registered. First push into an empty FIFO gives out_valid=1 in the next cycle.
//     - out_data is stable while out_valid & !out_ready.
//     - Pointers wrap modulo FIFO_DEPTH.
//     - Count uses log2(FIFO_DEPTH)+1 bits so full and empty are unambiguous.
//   Counter:
//     - cnt increments every cycle and wraps 32'hFFFF_FFFF -> 0.
//     - A clearing write sets cnt=0 at that edge, with no increment on that edge.
//     - It then reads 0 in the next cycle, 1 in the one after, and so on.
//   Sticky-bit conflicts: a set and a W1C in the same cycle -> set wins.
//   Reset (rst=0, asynchronous), all fields below hold in reset:
//     - cnt=0, shadow=0
//     - FIFO empty: out_valid=0, out_data=8'h00
//     - ovf=0, prot_err=0
//     - memRead=0 unless memRE=1
//   Reset mid-operation: FIFO contents are discarded; in-flight writes at the reset edge are lost.
// CONFIGURATION
//   Macro RCPU_MEM_WPROT_EN:
//     - Defined: RAM writes to memAddr < ROM_WORDS are ignored and set prot_err (STATUS bit 3). Reads are unaffected.
//     - Undefined: the whole RAM is writable and STATUS bit 3 always reads 0.
// TESTING
//   1. Assert rst=0 mid-run, release -> out_valid=0; STATUS read=16'h0001; memRead=0 while memRE=0.
//   2. Write 16'h1234 to 0x0000_C000, then read -> 16'h1234. Read 0x0010_0000 -> 16'h0000.
//   3. out_ready=0; write 0x41 then 0x42 to CONOUT -> out_valid=1, out_data=0x41 one cycle after the first write. Raise out_ready -> 0x41, then 0x42, then out_valid=0.
//   4. FIFO_DEPTH=8, out_ready=0, 9 CONOUT writes -> STATUS=16'h0006 and the 9th byte is absent on drain. Write STATUS=16'h0004 -> STATUS=16'h0002.
//   5. Write CYC_LO in cycle 0; read CYC_LO in cycle 101 -> 16'h0064. Read at cycle 65537 -> 16'h0000, then CYC_HI -> 16'h0001.
//   6. Write 16'h00FF to 0x0000_0010 with the macro defined -> the read returns the prior value and STATUS bit 3=1. Without the macro -> the read returns 16'h00FF.

Source files
------------

// File: rtl/rcpu_mem_responder.sv
// rcpu_mem_responder: responder end of the RCPU memory bus.
// Serves word RAM, a console byte FIFO with a valid/ready drain port,
// a status register and a free-running 32-bit cycle counter.
// Read data is combinational (zero wait states).
// Optional feature macro: RCPU_MEM_WPROT_EN (write-protects RAM words below ROM_WORDS).
module rcpu_mem_responder #(
    parameter int              M          = 16,
    parameter int              N          = 32,
    parameter int              RAM_AW     = 16,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [N-1:0]    MMIO_BASE  = 32'hFFFF_FF00,
    parameter int              ROM_WORDS  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  memAddr,
    output logic [M-1:0]  memRead,
    input  logic [M-1:0]  memWrite,
    input  logic          memRE,
    input  logic          memWE,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Address decode
    logic       isRam;
    logic       isMmio;
    logic [7:0] regOff;
    logic       selConout;
    logic       selStatus;
    logic       selCycLo;
    logic       selCycHi;

    assign isRam     = (memAddr[N-1:RAM_AW] == '0);
    assign isMmio    = (memAddr[N-1:8] == MMIO_BASE[N-1:8]);
    assign regOff    = memAddr[7:0];
    assign selConout = isMmio && (regOff == 8'd0);
    assign selStatus = isMmio && (regOff == 8'd1);
    assign selCycLo  = isMmio && (regOff == 8'd2);
    assign selCycHi  = isMmio && (regOff == 8'd3);

    // RAM storage and write-protection decode
    logic [M-1:0] ram [2**RAM_AW];
    logic         ramWe;
    logic         protErr;

`ifdef RCPU_MEM_WPROT_EN
    localparam logic [N-1:0] ROM_LIMIT = N'(ROM_WORDS);
    logic protHit;
    assign protHit = memWE && isRam && (memAddr < ROM_LIMIT);
    assign ramWe   = memWE && isRam && !protHit;

    // Sticky protection-error flag; a new violation wins over a W1C in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            protErr <= 1'b0;
        end else if (protHit) begin
            protErr <= 1'b1;
        end else if (memWE && selStatus && memWrite[3]) begin
            protErr <= 1'b0;
        end
    end
`else
    assign ramWe   = memWE && isRam;
    assign protErr = 1'b0;
`endif

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[memAddr[RAM_AW-1:0]] <= memWrite;
        end
    end

    // Console FIFO.
    // Drain handshake: a byte transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid never drops and out_data never changes
    // while a byte is offered and not yet accepted; out_ready may toggle freely.
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdPtrNext;
    logic [CNT_W-1:0] fifoCnt;
    logic [CNT_W-1:0] cntAfterPop;
    logic [CNT_W-1:0] cntNext;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             doPush;
    logic             doPop;
    logic             dropByte;
    logic [7:0]       headNext;
    logic             ovf;

    assign fifoFull    = (fifoCnt == DEPTH_C);
    assign fifoEmpty   = (fifoCnt == '0);
    assign doPush      = memWE && selConout && !fifoFull;
    assign dropByte    = memWE && selConout && fifoFull;
    assign doPop       = out_valid && out_ready;
    assign rdPtrNext   = rdPtr + PTR_W'(doPop);
    assign cntAfterPop = fifoCnt - CNT_W'(doPop);
    assign cntNext     = cntAfterPop + CNT_W'(doPush);
    // A byte pushed into an (effectively) empty FIFO becomes the head directly
    assign headNext    = (cntAfterPop == '0) ? memWrite[7:0] : fifoMem[rdPtrNext];

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= memWrite[7:0];
        end
    end

    // FIFO pointers, occupancy and registered head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            wrPtr     <= wrPtr + PTR_W'(doPush);
            rdPtr     <= rdPtrNext;
            fifoCnt   <= cntNext;
            out_valid <= (cntNext != '0);
            if (cntNext != '0) begin
                out_data <= headNext;
            end
        end
    end

    // Sticky overflow flag; an overflow wins over a W1C in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (dropByte) begin
            ovf <= 1'b1;
        end else if (memWE && selStatus && memWrite[2]) begin
            ovf <= 1'b0;
        end
    end

    // Cycle counter with clear-on-write and high-half shadow latched by CYC_LO reads
    logic [31:0]  cnt;
    logic [M-1:0] shadow;
    logic         cntClear;

    assign cntClear = memWE && (selCycLo || selCycHi);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            shadow <= '0;
        end else begin
            cnt <= cntClear ? 32'd0 : cnt + 32'd1;
            if (memRE && selCycLo) begin
                shadow <= cnt[2*M-1:M];
            end
        end
    end

    // Combinational read mux; zero when not reading or unmapped
    always_comb begin
        memRead = '0;
        if (memRE) begin
            if (isRam) begin
                memRead = ram[memAddr[RAM_AW-1:0]];
            end else if (isMmio) begin
                case (regOff)
                    8'd1:    memRead = {{(M-4){1'b0}}, protErr, ovf, fifoFull, fifoEmpty};
                    8'd2:    memRead = cnt[M-1:0];
                    8'd3:    memRead = shadow;
                    default: memRead = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rcpu_mem_responder.sv
// Bench for rcpu_mem_responder: directed scenarios plus randomized traffic
// checked against a behavioural model (RAM map, byte queue, counter value).
module tb_rcpu_mem_responder;

    localparam logic [31:0] CONOUT = 32'hFFFF_FF00;
    localparam logic [31:0] STATUS = 32'hFFFF_FF01;
    localparam logic [31:0] CYC_LO = 32'hFFFF_FF02;
    localparam logic [31:0] CYC_HI = 32'hFFFF_FF03;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [31:0] memAddr = '0;
    logic [15:0] memRead;
    logic [15:0] memWrite = '0;
    logic        memRE = 1'b0;
    logic        memWE = 1'b0;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady = 1'b0;

    rcpu_mem_responder dut (
        .clk       (clk),
        .rst       (rstN),
        .memAddr   (memAddr),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memRE     (memRE),
        .memWE     (memWE),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    // Clock: period 10
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] ramM [int];
    logic [7:0]  expQ [$];
    logic        mOvf;
    logic        mProt;
    logic [31:0] mCnt;
    logic [15:0] mShadow;

    // Per-step observations and expectations
    logic [15:0] obsRead;
    logic        obsValid;
    logic [7:0]  obsData;
    logic [15:0] expRead;
    logic        expReadKnown;
    logic        expValid;
    logic [7:0]  expData;

    int vectors = 0;
    int errors  = 0;

    function automatic logic [15:0] statusWord();
        return {12'b0, mProt, mOvf, expQ.size() == 8, expQ.size() == 0};
    endfunction

    task automatic modelReset();
        expQ.delete();
        mOvf    = 1'b0;
        mProt   = 1'b0;
        mCnt    = 32'd0;
        mShadow = 16'd0;
    endtask

    // One bus cycle: drive at posedge+1, sample at negedge+1, update model at posedge
    task automatic step(input logic we, input logic re, input logic [31:0] addr,
                        input logic [15:0] wd, input logic rdy);
        logic       wasFull;
        logic       mmio;
        logic [7:0] off;
        memWE    = we;
        memRE    = re;
        memAddr  = addr;
        memWrite = wd;
        outReady = rdy;
        @(negedge clk);
        #1;
        obsRead  = memRead;
        obsValid = outValid;
        obsData  = outData;
        mmio     = (addr[31:8] == 24'hFF_FFFF);
        off      = addr[7:0];
        expValid = (expQ.size() != 0);
        expData  = expValid ? expQ[0] : 8'h00;
        expReadKnown = 1'b1;
        expRead      = 16'h0000;
        if (re) begin
            if (addr < 32'h0001_0000) begin
                if (ramM.exists(int'(addr))) expRead = ramM[int'(addr)];
                else expReadKnown = 1'b0;
            end else if (mmio) begin
                case (off)
                    8'd1:    expRead = statusWord();
                    8'd2:    expRead = mCnt[15:0];
                    8'd3:    expRead = mShadow;
                    default: expRead = 16'h0000;
                endcase
            end
        end
        @(posedge clk);
        if (rstN) begin
            wasFull = (expQ.size() == 8);
            if (expValid && rdy) void'(expQ.pop_front());
            if (re && mmio && off == 8'd2) mShadow = mCnt[31:16];
            if (we && mmio && (off == 8'd2 || off == 8'd3)) mCnt = 32'd0;
            else mCnt = mCnt + 32'd1;
            if (we && mmio && off == 8'd1) begin
                if (wd[3]) mProt = 1'b0;
                if (wd[2]) mOvf = 1'b0;
            end
            if (we && mmio && off == 8'd0) begin
                if (wasFull) mOvf = 1'b1;
                else expQ.push_back(wd[7:0]);
            end
            if (we && addr < 32'h0001_0000) begin
`ifdef RCPU_MEM_WPROT_EN
                if (addr < 32'd256) mProt = 1'b1;
                else ramM[int'(addr)] = wd;
`else
                ramM[int'(addr)] = wd;
`endif
            end
        end
        #1;
    endtask

    task automatic doReset();
        memWE = 1'b0;
        memRE = 1'b0;
        outReady = 1'b0;
        rstN = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, CONOUT, 16'h0011, 1'b0);
        step(1'b1, 1'b0, CONOUT, 16'h0022, 1'b0);
        step(1'b1, 1'b0, CONOUT, 16'h0033, 1'b0);
        #3;
        rstN = 1'b0;
        #1;
        vectors++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_valid: got %b expected 0", outValid);
        end
        vectors++;
        if (outData !== 8'h00) begin
            errors++;
            $display("FAIL reset_async_data: got %h expected 00", outData);
        end
        memWE = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        step(1'b0, 1'b1, STATUS, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0001) begin
            errors++;
            $display("FAIL reset_status: got %h expected 0001", obsRead);
        end
        vectors++;
        if (obsValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", obsValid);
        end
        step(1'b0, 1'b0, 32'h0000_C000, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0000) begin
            errors++;
            $display("FAIL reset_idle_read: got %h expected 0000", obsRead);
        end
    endtask

    task automatic test_ram();
        step(1'b1, 1'b0, 32'h0000_C000, 16'h1234, 1'b0);
        step(1'b0, 1'b1, 32'h0000_C000, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h1234) begin
            errors++;
            $display("FAIL ram_read: got %h expected 1234", obsRead);
        end
        step(1'b1, 1'b1, 32'h0000_C000, 16'hBEEF, 1'b0);
        vectors++;
        if (obsRead !== 16'h1234) begin
            errors++;
            $display("FAIL ram_read_during_write: got %h expected 1234", obsRead);
        end
        step(1'b0, 1'b1, 32'h0000_C000, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'hBEEF) begin
            errors++;
            $display("FAIL ram_write_landed: got %h expected beef", obsRead);
        end
        step(1'b0, 1'b1, 32'h0010_0000, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0000) begin
            errors++;
            $display("FAIL unmapped_read: got %h expected 0000", obsRead);
        end
    endtask

    task automatic test_fifo();
        step(1'b1, 1'b0, CONOUT, 16'h0041, 1'b0);
        vectors++;
        if (obsValid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_empty_before: got %b expected 0", obsValid);
        end
        step(1'b1, 1'b0, CONOUT, 16'h0042, 1'b0);
        vectors++;
        if (obsValid !== 1'b1 || obsData !== 8'h41) begin
            errors++;
            $display("FAIL fifo_first_head: got v=%b d=%h expected v=1 d=41", obsValid, obsData);
        end
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
        vectors++;
        if (obsValid !== 1'b1 || obsData !== 8'h41) begin
            errors++;
            $display("FAIL fifo_drain0: got v=%b d=%h expected v=1 d=41", obsValid, obsData);
        end
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
        vectors++;
        if (obsValid !== 1'b1 || obsData !== 8'h42) begin
            errors++;
            $display("FAIL fifo_drain1: got v=%b d=%h expected v=1 d=42", obsValid, obsData);
        end
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        vectors++;
        if (obsValid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: got %b expected 0", obsValid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, CONOUT, 16'(16'h0030 + i), 1'b0);
        step(1'b0, 1'b1, STATUS, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0006) begin
            errors++;
            $display("FAIL ovf_status: got %h expected 0006", obsRead);
        end
        step(1'b1, 1'b0, STATUS, 16'h0004, 1'b0);
        step(1'b0, 1'b1, STATUS, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0002) begin
            errors++;
            $display("FAIL ovf_w1c: got %h expected 0002", obsRead);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
            vectors++;
            if (obsValid !== 1'b1 || obsData !== 8'(8'h30 + i)) begin
                errors++;
                $display("FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h", i, obsValid, obsData, 8'(8'h30 + i));
            end
        end
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        vectors++;
        if (obsValid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_ninth_absent: got v=%b d=%h expected v=0", obsValid, obsData);
        end
    endtask

    task automatic test_wprot();
        step(1'b1, 1'b0, 32'h0000_0010, 16'h00FF, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0010, 16'h0000, 1'b0);
`ifdef RCPU_MEM_WPROT_EN
        vectors++;
        if (obsRead === 16'h00FF) begin
            errors++;
            $display("FAIL wprot_read: got %h expected prior value (not 00ff)", obsRead);
        end
        step(1'b0, 1'b1, STATUS, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0009) begin
            errors++;
            $display("FAIL wprot_status: got %h expected 0009", obsRead);
        end
        step(1'b1, 1'b0, STATUS, 16'h0008, 1'b0);
`else
        vectors++;
        if (obsRead !== 16'h00FF) begin
            errors++;
            $display("FAIL wprot_read: got %h expected 00ff", obsRead);
        end
        step(1'b0, 1'b1, STATUS, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0001) begin
            errors++;
            $display("FAIL wprot_status: got %h expected 0001", obsRead);
        end
`endif
    endtask

    task automatic test_counter();
        step(1'b1, 1'b0, CYC_LO, 16'h0000, 1'b0);
        repeat (100) step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        step(1'b0, 1'b1, CYC_LO, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0064) begin
            errors++;
            $display("FAIL cyc_lo_101: got %h expected 0064", obsRead);
        end
        repeat (65435) step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        step(1'b0, 1'b1, CYC_LO, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0000) begin
            errors++;
            $display("FAIL cyc_lo_65537: got %h expected 0000", obsRead);
        end
        step(1'b0, 1'b1, CYC_HI, 16'h0000, 1'b0);
        vectors++;
        if (obsRead !== 16'h0001) begin
            errors++;
            $display("FAIL cyc_hi_shadow: got %h expected 0001", obsRead);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          kind;
        for (int n = 0; n < 1500; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3)      addr = 32'($urandom_range(0, 15));
            else if (kind < 4) addr = 32'h0000_0200 + 32'($urandom_range(0, 15));
            else if (kind < 8) addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 4));
            else if (kind < 9) addr = 32'h0010_0000 + 32'($urandom_range(0, 3));
            else               addr = 32'h0000_C000 + 32'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
                 16'($urandom), ($urandom_range(0, 2) == 0));
            if (expReadKnown) begin
                vectors++;
                if (obsRead !== expRead) begin
                    errors++;
                    $display("FAIL rand_read[%0d] addr=%h: got %h expected %h", n, addr, obsRead, expRead);
                end
            end
            vectors++;
            if (obsValid !== expValid) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %b expected %b", n, obsValid, expValid);
            end
            if (expValid) begin
                vectors++;
                if (obsData !== expData) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", n, obsData, expData);
                end
            end
        end
    endtask

    initial begin
        doReset();
        test_reset();
        test_ram();
        test_fifo();
        test_overflow();
        test_wprot();
        test_counter();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
